// File: rtl/dpram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpram_pkg: frame-exchange state type, DSP memory-map constants, helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COPY     = 2'd1,
    XINT     = 2'd2,
    WAIT_ACK = 2'd3
  } frameState_t;

  localparam logic [15:0] c_BASE_ADDR     = 16'h0000;
  localparam logic [15:0] c_ACK_ADDR      = 16'h00FF;
  localparam logic        c_STROBE_ACTIVE = 1'b0;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_frame_scheduler_dsp_bus_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dsp_bus_sync: DSP strobe synchronizers, read-address capture, ack detect
// Revision: 1.0
// ----------------------------------------------------------------------------
module dsp_bus_sync
  import dpram_pkg::*;
#(
  parameter logic [15:0] ACK_ADDR = c_ACK_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_XZCS6,
  input  logic        i_XRD,
  input  logic        i_XWE,
  input  logic [15:0] i_DSP_A,
  output logic        o_dspAct,
  output logic        o_ackEvent
);

  logic [1:0]  r_zcsSync;
  logic [1:0]  r_rdSync;
  logic [1:0]  r_weSync;
  logic        r_rdPrev;
  logic [15:0] r_capAddr;

  logic w_zcsOn;
  logic w_rdOn;
  logic w_weOn;
  logic w_rdFall;
  logic w_rdRise;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_zcsSync <= {2{~c_STROBE_ACTIVE}};
      r_rdSync  <= {2{~c_STROBE_ACTIVE}};
      r_weSync  <= {2{~c_STROBE_ACTIVE}};
      r_rdPrev  <= ~c_STROBE_ACTIVE;
      r_capAddr <= '0;
    end else begin
      r_zcsSync <= {r_zcsSync[0], i_XZCS6};
      r_rdSync  <= {r_rdSync[0], i_XRD};
      r_weSync  <= {r_weSync[0], i_XWE};
      r_rdPrev  <= r_rdSync[1];
      // The bus address is long stable by the time the synced strobe falls.
      if (w_rdFall) begin
        r_capAddr <= i_DSP_A;
      end
    end
  end

  assign w_zcsOn  = (r_zcsSync[1] == c_STROBE_ACTIVE);
  assign w_rdOn   = (r_rdSync[1] == c_STROBE_ACTIVE);
  assign w_weOn   = (r_weSync[1] == c_STROBE_ACTIVE);
  assign w_rdFall = w_rdOn && (r_rdPrev != c_STROBE_ACTIVE);
  assign w_rdRise = !w_rdOn && (r_rdPrev == c_STROBE_ACTIVE);

  assign o_dspAct   = w_zcsOn && (w_rdOn || w_weOn);
  assign o_ackEvent = w_rdRise && w_zcsOn && (r_capAddr == ACK_ADDR);

endmodule
`default_nettype wire

// File: rtl/dpram_frame_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dpram_frame_scheduler: copies status words into the DPRAM, interrupts the
// DSP and supervises its acknowledge. Revision: 1.0
// ----------------------------------------------------------------------------
module dpram_frame_scheduler
  import dpram_pkg::*;
#(
  parameter int          N_WORDS     = 32,
  parameter logic [15:0] BASE_ADDR   = c_BASE_ADDR,
  parameter logic [15:0] ACK_ADDR    = c_ACK_ADDR,
  parameter int          XINT_CYC    = 20,
  parameter int          TIMEOUT_CYC = 50000,
  parameter int          ERR_LIMIT   = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_xint_st,
  input  logic        i_XZCS6,
  input  logic        i_XRD,
  input  logic        i_XWE,
  input  logic [15:0] i_DSP_A,
  output logic [7:0]  o_word_idx,
  input  logic [15:0] i_word_data,
  output logic        o_ram_we,
  output logic [15:0] o_ram_addr,
  output logic [15:0] o_ram_wdata,
  output logic        o_XINT1,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic [7:0]  o_miss_cnt,
  output logic        o_overrun,
  output logic        o_sumerr_DSP
);

  localparam int c_TMR_MAX = (TIMEOUT_CYC > XINT_CYC) ? TIMEOUT_CYC : XINT_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX) + 1;

  frameState_t        r_state;
  logic [7:0]         r_wordIdx;
  logic               r_ramWe;
  logic [15:0]        r_ramAddr;
  logic [15:0]        r_ramWdata;
  logic               r_xint1;
  logic               r_busy;
  logic [15:0]        r_frameCnt;
  logic [7:0]         r_missCnt;
  logic [7:0]         r_consecMiss;
  logic               r_overrun;
  logic               r_sumerr;
  logic [c_TMR_W-1:0] r_timer;

  logic       w_dspAct;
  logic       w_ackEvent;
  logic       w_lastWord;
  logic       w_xintDone;
  logic       w_timeout;
  logic [7:0] w_consecNext;

  dsp_bus_sync #(
    .ACK_ADDR (ACK_ADDR)
  ) u_dspBusSync (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_XZCS6    (i_XZCS6),
    .i_XRD      (i_XRD),
    .i_XWE      (i_XWE),
    .i_DSP_A    (i_DSP_A),
    .o_dspAct   (w_dspAct),
    .o_ackEvent (w_ackEvent)
  );

  assign w_lastWord   = (r_wordIdx == 8'(N_WORDS - 1));
  assign w_xintDone   = (r_timer == c_TMR_W'(XINT_CYC - 1));
  assign w_timeout    = (r_timer == c_TMR_W'(TIMEOUT_CYC - 1));
  assign w_consecNext = satInc8(r_consecMiss);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_wordIdx    <= '0;
      r_ramWe      <= 1'b0;
      r_ramAddr    <= '0;
      r_ramWdata   <= '0;
      r_xint1      <= 1'b1;
      r_busy       <= 1'b0;
      r_frameCnt   <= '0;
      r_missCnt    <= '0;
      r_consecMiss <= '0;
      r_overrun    <= 1'b0;
      r_sumerr     <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_ramWe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_xint_st) begin
            r_wordIdx <= '0;
            r_busy    <= 1'b1;
            r_state   <= COPY;
          end
        end

        COPY: begin
          if (i_xint_st) begin
            r_overrun <= 1'b1;
          end
          // DSP owns the RAM while active; the copy simply holds its index.
          if (!w_dspAct) begin
            r_ramWe    <= 1'b1;
            r_ramAddr  <= BASE_ADDR + {8'h00, r_wordIdx};
            r_ramWdata <= i_word_data;
            r_wordIdx  <= r_wordIdx + 8'd1;
            if (w_lastWord) begin
              r_frameCnt <= r_frameCnt + 16'd1;
              r_xint1    <= 1'b0;
              r_timer    <= '0;
              r_state    <= XINT;
            end
          end
        end

        XINT: begin
          if (i_xint_st) begin
            r_overrun <= 1'b1;
          end
          if (w_xintDone) begin
            r_xint1 <= 1'b1;
            r_timer <= '0;
            r_state <= WAIT_ACK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        WAIT_ACK: begin
          // A start pulse coinciding with the exit is dropped without overrun.
          if (w_ackEvent) begin
            r_consecMiss <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else if (w_timeout) begin
            r_missCnt    <= satInc8(r_missCnt);
            r_consecMiss <= w_consecNext;
            if (int'(w_consecNext) >= ERR_LIMIT) begin
              r_sumerr <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (i_xint_st) begin
              r_overrun <= 1'b1;
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_xint1 <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_word_idx   = r_wordIdx;
  assign o_ram_we     = r_ramWe;
  assign o_ram_addr   = r_ramAddr;
  assign o_ram_wdata  = r_ramWdata;
  assign o_XINT1      = r_xint1;
  assign o_busy       = r_busy;
  assign o_frame_cnt  = r_frameCnt;
  assign o_miss_cnt   = r_missCnt;
  assign o_overrun    = r_overrun;
  assign o_sumerr_DSP = r_sumerr;

endmodule
`default_nettype wire

// File: tb/tb_dpram_frame_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dpram_frame_scheduler: randomized frames checked against a frame-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dpram_frame_scheduler;

  localparam int          N_WORDS     = 32;
  localparam int          XINT_CYC    = 20;
  localparam int          TIMEOUT_CYC = 64;
  localparam int          ERR_LIMIT   = 3;
  localparam logic [15:0] BASE_ADDR   = 16'h0000;
  localparam logic [15:0] ACK_ADDR    = 16'h00FF;

  localparam int MODE_NONE  = 0;
  localparam int MODE_ACK   = 1;
  localparam int MODE_WRONG = 2;

  logic        clk    = 1'b0;
  logic        resetN = 1'b0;
  logic        xintSt = 1'b0;
  logic        xzcs6  = 1'b1;
  logic        xrd    = 1'b1;
  logic        xwe    = 1'b1;
  logic [15:0] dspA   = '0;
  logic [15:0] salt   = 16'h1000;
  logic [15:0] wordData;
  logic [7:0]  wordIdx;
  logic        ramWe;
  logic [15:0] ramAddr;
  logic [15:0] ramWdata;
  logic        xint1;
  logic        busy;
  logic [15:0] frameCnt;
  logic [7:0]  missCnt;
  logic        overrun;
  logic        sumerr;

  always #5 clk = ~clk;

  assign wordData = salt + {8'h00, wordIdx};

  dpram_frame_scheduler #(
    .N_WORDS     (N_WORDS),
    .BASE_ADDR   (BASE_ADDR),
    .ACK_ADDR    (ACK_ADDR),
    .XINT_CYC    (XINT_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ERR_LIMIT   (ERR_LIMIT)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (resetN),
    .i_xint_st    (xintSt),
    .i_XZCS6      (xzcs6),
    .i_XRD        (xrd),
    .i_XWE        (xwe),
    .i_DSP_A      (dspA),
    .o_word_idx   (wordIdx),
    .i_word_data  (wordData),
    .o_ram_we     (ramWe),
    .o_ram_addr   (ramAddr),
    .o_ram_wdata  (ramWdata),
    .o_XINT1      (xint1),
    .o_busy       (busy),
    .o_frame_cnt  (frameCnt),
    .o_miss_cnt   (missCnt),
    .o_overrun    (overrun),
    .o_sumerr_DSP (sumerr)
  );

  // Passive monitor: logs RAM writes and interrupt/busy edges with cycle stamps.
  int          cyc         = 0;
  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];
  int          wrCyc[$];
  int          xintLow     = 0;
  int          xintRiseCyc = -1;
  int          busyFallCyc = -1;
  logic        xintPrev    = 1'b1;
  logic        busyPrev    = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ramWe) begin
      wrAddr.push_back(ramAddr);
      wrData.push_back(ramWdata);
      wrCyc.push_back(cyc);
    end
    if (!xint1) xintLow++;
    if (xint1 && !xintPrev) xintRiseCyc = cyc;
    if (!busy && busyPrev) busyFallCyc = cyc;
    xintPrev = xint1;
    busyPrev = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference model
  logic [15:0] mFrame   = '0;
  int          mMiss    = 0;
  int          mConsec  = 0;
  logic        mSumerr  = 1'b0;
  logic        mOverrun = 1'b0;

  task automatic dspRead(input logic [15:0] addr);
    dspA  = addr;
    xzcs6 = 1'b0;
    xrd   = 1'b0;
    repeat (3) @(posedge clk);
    #1 xrd = 1'b1;
    repeat (3) @(posedge clk);
    #1 xzcs6 = 1'b1;
  endtask

  task automatic runFrame(input int mode, input bit doStall, input bit doOverrun,
                          input bit doExitPulse, input bit fixedSalt);
    int startCyc;
    int wrBase;
    int lowBase;
    int stallLen;
    int k;
    int guard;
    int bad;
    int n;
    int d;
    stallLen = 0;
    salt     = fixedSalt ? 16'h1000 : 16'($urandom);
    startCyc = cyc;
    wrBase   = wrAddr.size();
    lowBase  = xintLow;

    @(posedge clk); #1 xintSt = 1'b1;
    @(posedge clk); #1 xintSt = 1'b0;

    if (doStall) begin
      k        = $urandom_range(2, 20);
      stallLen = $urandom_range(1, 6);
      guard    = 0;
      while ((wrAddr.size() - wrBase) < k && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      #1;
      // Ack-address reads during the copy must not end the frame early.
      dspA  = $urandom_range(0, 1) ? ACK_ADDR : 16'($urandom);
      xzcs6 = 1'b0;
      if ($urandom_range(0, 1) == 1) xrd = 1'b0;
      else                            xwe = 1'b0;
      repeat (stallLen) @(posedge clk);
      #1 xrd = 1'b1; xwe = 1'b1;
      @(posedge clk);
      #1 xzcs6 = 1'b1;
    end

    if (doOverrun) begin
      guard = 0;
      while ((wrAddr.size() - wrBase) < 26 && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      #1 xintSt = 1'b1;
      @(posedge clk); #1 xintSt = 1'b0;
      mOverrun = 1'b1;
    end

    guard = 0;
    while (!(xintRiseCyc > startCyc) && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    checkEq("xint_rise_seen", 32'(xintRiseCyc > startCyc), 1);

    if (mode == MODE_ACK) begin
      d = $urandom_range(0, TIMEOUT_CYC - 24);
      repeat (d) @(posedge clk);
      #1 dspRead(ACK_ADDR);
    end else if (mode == MODE_WRONG) begin
      d = $urandom_range(0, TIMEOUT_CYC - 24);
      repeat (d) @(posedge clk);
      #1 dspRead(ACK_ADDR - 16'd1);
    end else if (doExitPulse) begin
      // Land the start pulse on the exact clock the timeout releases the frame.
      repeat (TIMEOUT_CYC - 2) @(posedge clk);
      #1 xintSt = 1'b1;
      @(posedge clk); #1 xintSt = 1'b0;
    end

    guard = 0;
    while (!(busyFallCyc > startCyc) && guard < TIMEOUT_CYC + 100) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;

    mFrame = mFrame + 16'd1;
    if (mode == MODE_ACK) begin
      mConsec = 0;
    end else begin
      if (mMiss < 255) mMiss++;
      mConsec++;
      if (mConsec >= ERR_LIMIT) mSumerr = 1'b1;
    end

    n = wrAddr.size() - wrBase;
    checkEq("write_count", n, N_WORDS);
    bad = 0;
    for (int i = 0; i < N_WORDS && i < n; i++) begin
      if (wrAddr[wrBase + i] !== 16'(BASE_ADDR + i)) bad++;
      if (wrData[wrBase + i] !== 16'(salt + i)) bad++;
    end
    checkEq("write_sequence_errs", bad, 0);
    if (n >= N_WORDS) begin
      checkEq("copy_span", wrCyc[wrBase + N_WORDS - 1] - wrCyc[wrBase], N_WORDS - 1 + stallLen);
    end
    checkEq("xint_low_cycles", xintLow - lowBase, XINT_CYC);
    if (mode == MODE_ACK) begin
      checkEq("ack_before_timeout", 32'((busyFallCyc - xintRiseCyc) < TIMEOUT_CYC), 1);
    end else begin
      checkEq("timeout_latency", busyFallCyc - xintRiseCyc, TIMEOUT_CYC);
    end
    checkEq("frame_cnt", frameCnt, mFrame);
    checkEq("miss_cnt", missCnt, mMiss);
    checkEq("sumerr", sumerr, mSumerr);
    checkEq("overrun", overrun, mOverrun);
    checkEq("busy_idle", busy, 0);
    checkEq("xint1_idle", xint1, 1);
  endtask

  task automatic checkCleared(input string phase);
    checkEq({phase, "_ram_we"}, ramWe, 0);
    checkEq({phase, "_ram_addr"}, ramAddr, 0);
    checkEq({phase, "_ram_wdata"}, ramWdata, 0);
    checkEq({phase, "_word_idx"}, wordIdx, 0);
    checkEq({phase, "_xint1"}, xint1, 1);
    checkEq({phase, "_busy"}, busy, 0);
    checkEq({phase, "_frame_cnt"}, frameCnt, 0);
    checkEq({phase, "_miss_cnt"}, missCnt, 0);
    checkEq({phase, "_overrun"}, overrun, 0);
    checkEq({phase, "_sumerr"}, sumerr, 0);
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 checkCleared("reset");
    @(negedge clk) resetN = 1'b1;
    repeat (2) @(posedge clk);

    // Directed opening: clean ack, stalled ack, wrong-address read, two silent
    // frames (reaching the error limit), then an acked frame with an overrun.
    runFrame(MODE_ACK,   1'b0, 1'b0, 1'b0, 1'b1);
    runFrame(MODE_ACK,   1'b1, 1'b0, 1'b0, 1'b0);
    runFrame(MODE_WRONG, 1'b1, 1'b0, 1'b0, 1'b0);
    runFrame(MODE_NONE,  1'b0, 1'b0, 1'b1, 1'b0);
    runFrame(MODE_NONE,  1'b1, 1'b0, 1'b0, 1'b0);
    runFrame(MODE_ACK,   1'b0, 1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      runFrame($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0,
               1'b0, 1'b0);
    end

    // Enough consecutive misses to push the miss counter past saturation.
    for (int f = 0; f < 260; f++) begin
      runFrame(MODE_NONE, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    checkEq("miss_cnt_saturated", missCnt, 255);

    // Asynchronous reset in the middle of a copy.
    @(posedge clk); #1 xintSt = 1'b1;
    @(posedge clk); #1 xintSt = 1'b0;
    guard = 0;
    while (wordIdx < 8'd5 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    checkEq("copy_in_progress", 32'(busy), 1);
    #3 resetN = 1'b0;
    #1 checkCleared("async_reset");
    @(negedge clk) resetN = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
